// File: rtl/alu_32b_arbiter.sv
// Two-port round-robin front end for a single alu_32b: accepts one operation at a time,
// holds operands on the ALU for ALU_LATENCY cycles, then returns the result to the winner.
module alu_32b_arbiter #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 6,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a request; req_ready offered to the round-robin winner
  // EXEC  | operands held on the ALU, counter runs down to the capture cycle
  // RESP  | result held on rsp_result until the granted port takes it

  if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
    $error("alu_32b_arbiter: ALU_LATENCY must be in 1..15");
  end

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [3:0] counter;
  logic       grant;
  logic       last_grant;
  logic       sel;
  logic       any_valid;

  // On contention the port that did not win last time is chosen.
  always_comb begin
    any_valid = |req_valid;
    sel       = (&req_valid) ? ~last_grant : req_valid[1];
    req_ready = 2'b00;
    if (state == IDLE && any_valid) req_ready[sel] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= 4'd0;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      rsp_valid     <= 2'b00;
      rsp_result    <= '0;
      alu_operandA  <= '0;
      alu_operandB  <= '0;
      alu_operation <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant         <= sel;
            alu_operandA  <= sel ? req_a1 : req_a0;
            alu_operandB  <= sel ? req_b1 : req_b0;
            alu_operation <= sel ? req_op1 : req_op0;
            counter       <= LAT;
            state         <= EXEC;
          end
        end
        EXEC: begin
          counter <= counter - 4'd1;
          if (counter == 4'd1) begin
            rsp_result <= alu_result;
            rsp_valid  <= grant ? 2'b10 : 2'b01;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            last_grant <= grant;
            rsp_valid  <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
